jtcps1_obj_draw: RTL and testbench

JTCPS1_OBJ_DRAW -- requirements
Module: jtcps1_obj_draw

---
 rtl/jtcps1_obj_pkg.sv | 43 ++++
 rtl/jtcps1_obj_pxl.sv | 46 ++++
 rtl/jtcps1_obj_draw.sv | 205 ++++++++++++++++++++
 tb/tb_jtcps1_obj_draw.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtcps1_obj_pkg.sv
// Shared definitions for the CPS1 object line renderer.
// Provides the FSM state encoding, table layout constants, the line buffer
// pixel payload and the planar-to-packed pixel helper.
package jtcps1_obj_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD0,
        ST_RD1,
        ST_RD2,
        ST_FETCH,
        ST_DRAW,
        ST_NEXT
    } obj_state_e;

    localparam logic [15:0] OBJ_TERMINATOR  = 16'hFFFF;
    localparam logic [3:0]  OBJ_TRANSPARENT = 4'hF;
    localparam int unsigned OBJ_ENTRIES     = 128;
    localparam int unsigned OBJ_STRIDE      = 4;
    localparam int unsigned ENTRY_W         = $clog2(OBJ_ENTRIES);
    localparam int unsigned WORD_W          = $clog2(OBJ_STRIDE);

    // Line buffer write payload
    typedef struct packed {
        logic [4:0] pal;
        logic [3:0] color;
    } obj_pixel_t;

    // Gather bit (7-i) of each plane (bit i when mirrored) into a 4-bit color
    function automatic logic [3:0] obj_pixel(input logic [31:0] d,
                                             input logic [2:0]  i,
                                             input logic        hflip);
        logic [7:0] p0, p1, p2, p3;
        logic [2:0] b;
        p0 = d[7:0];
        p1 = d[15:8];
        p2 = d[23:16];
        p3 = d[31:24];
        b  = hflip ? i : ~i;
        return {p3[b], p2[b], p1[b], p0[b]};
    endfunction

endpackage

// File: rtl/jtcps1_obj_pxl.sv
// Planar pixel serializer: holds one 32-bit ROM word (4 planes x 8 pixels)
// and presents one 4-bit color per clock.
// Ports: load latches data and rewinds the index; step advances the index;
// hflip selects reversed bit order; idx is the current pixel index;
// color_c is the color of the current pixel.
module jtcps1_obj_pxl
    import jtcps1_obj_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        step,
    input  logic        hflip,
    input  logic [31:0] data,
    output logic [2:0]  idx,
    output logic [3:0]  color_c
);

    logic [31:0] data_q, data_d;
    logic [2:0]  idx_q, idx_d;

    always_comb begin
        data_d = data_q;
        idx_d  = idx_q;
        if (load) begin
            data_d = data;
            idx_d  = 3'd0;
        end else if (step) begin
            idx_d = idx_q + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q <= '0;
            idx_q  <= '0;
        end else begin
            data_q <= data_d;
            idx_q  <= idx_d;
        end
    end

    assign idx     = idx_q;
    assign color_c = obj_pixel(data_q, idx_q, hflip);

endmodule

// File: rtl/jtcps1_obj_draw.sv
// CPS1 object line renderer: walks the per-line object table, fetches two
// 8-pixel halves of each object from ROM and writes opaque pixels into the
// line buffer.
// Ports: start/flip control; line_addr/line_data read the object table;
// rom_* perform handshaked tile fetches; buf_* write the line buffer;
// busy is high while a line is being rendered.
module jtcps1_obj_draw
    import jtcps1_obj_pkg::*;
#(
    parameter int unsigned AW = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          flip,
    output logic [8:0]    line_addr,
    input  logic [15:0]   line_data,
    output logic [19:0]   rom_addr,
    output logic          rom_half,
    output logic          rom_cs,
    input  logic          rom_ok,
    input  logic [31:0]   rom_data,
    output logic [AW-1:0] buf_addr,
    output logic [8:0]    buf_data,
    output logic          buf_wr,
    output logic          busy
);

    obj_state_e         state_q, state_d;
    logic [ENTRY_W-1:0] entry_q, entry_d;
    logic [3:0]         vsub_q, vsub_d;
    logic               hflip_q, hflip_d;
    logic [4:0]         pal_q, pal_d;
    logic [AW-1:0]      x_q, x_d;
    logic               second_q, second_d;
    logic [8:0]         line_addr_q, line_addr_d;
    logic [19:0]        rom_addr_q, rom_addr_d;
    logic               rom_half_q, rom_half_d;
    logic               rom_cs_q, rom_cs_d;
    logic [AW-1:0]      buf_addr_q, buf_addr_d;
    obj_pixel_t         buf_data_q, buf_data_d;
    logic               buf_wr_q, buf_wr_d;
    logic               busy_q, busy_d;

    logic          fetch_done_c;
    logic [2:0]    pix_idx;
    logic [3:0]    color_c;
    logic [AW-1:0] pix_pos_c;

    // Accepted handshake only while our own request is outstanding
    assign fetch_done_c = (state_q == ST_FETCH) && rom_cs_q && rom_ok;
    // 8*halfpos + i is just {halfpos, i}
    assign pix_pos_c    = x_q + AW'({second_q, pix_idx});

    jtcps1_obj_pxl u_pxl (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (fetch_done_c),
        .step    (state_q == ST_DRAW),
        .hflip   (hflip_q),
        .data    (rom_data),
        .idx     (pix_idx),
        .color_c (color_c)
    );

    // Next-state and registered output logic
    always_comb begin
        state_d     = state_q;
        entry_d     = entry_q;
        vsub_d      = vsub_q;
        hflip_d     = hflip_q;
        pal_d       = pal_q;
        x_d         = x_q;
        second_d    = second_q;
        line_addr_d = line_addr_q;
        rom_addr_d  = rom_addr_q;
        rom_half_d  = rom_half_q;
        rom_cs_d    = rom_cs_q;
        buf_addr_d  = buf_addr_q;
        buf_data_d  = buf_data_q;
        buf_wr_d    = 1'b0;
        busy_d      = busy_q;

        case (state_q)
            ST_IDLE: ;
            ST_RD0: begin
                line_addr_d = {entry_q, WORD_W'(1)};
                state_d     = ST_RD1;
            end
            ST_RD1: begin
                // word0 is on line_data now
                if (line_data == OBJ_TERMINATOR) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    vsub_d      = line_data[11:8];
                    hflip_d     = line_data[5];
                    pal_d       = line_data[4:0];
                    line_addr_d = {entry_q, WORD_W'(2)};
                    state_d     = ST_RD2;
                end
            end
            ST_RD2: begin
                // word1 (code) is on line_data now
                rom_addr_d = {line_data, vsub_q};
                rom_half_d = hflip_q;
                rom_cs_d   = 1'b1;
                second_d   = 1'b0;
                state_d    = ST_FETCH;
            end
            ST_FETCH: begin
                // word2 (x) stays on line_data while the first half is fetched
                if (!second_q) begin
                    x_d = line_data[AW-1:0];
                end
                if (fetch_done_c) begin
                    rom_cs_d = 1'b0;
                    state_d  = ST_DRAW;
                end
            end
            ST_DRAW: begin
                buf_addr_d = flip ? ~pix_pos_c : pix_pos_c;
                buf_data_d = '{pal: pal_q, color: color_c};
                buf_wr_d   = (color_c != OBJ_TRANSPARENT);
                if (pix_idx == 3'd7) begin
                    if (!second_q) begin
                        second_d   = 1'b1;
                        rom_half_d = ~hflip_q;
                        rom_cs_d   = 1'b1;
                        state_d    = ST_FETCH;
                    end else begin
                        state_d = ST_NEXT;
                    end
                end
            end
            ST_NEXT: begin
                if (entry_q == ENTRY_W'(OBJ_ENTRIES - 1)) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    entry_d     = entry_q + ENTRY_W'(1);
                    line_addr_d = {entry_q + ENTRY_W'(1), WORD_W'(0)};
                    state_d     = ST_RD0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A start pulse (re)begins the line from entry 0 in any state
        if (start) begin
            state_d     = ST_RD0;
            entry_d     = '0;
            line_addr_d = '0;
            rom_cs_d    = 1'b0;
            buf_wr_d    = 1'b0;
            busy_d      = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            entry_q     <= '0;
            vsub_q      <= '0;
            hflip_q     <= 1'b0;
            pal_q       <= '0;
            x_q         <= '0;
            second_q    <= 1'b0;
            line_addr_q <= '0;
            rom_addr_q  <= '0;
            rom_half_q  <= 1'b0;
            rom_cs_q    <= 1'b0;
            buf_addr_q  <= '0;
            buf_data_q  <= '0;
            buf_wr_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            entry_q     <= entry_d;
            vsub_q      <= vsub_d;
            hflip_q     <= hflip_d;
            pal_q       <= pal_d;
            x_q         <= x_d;
            second_q    <= second_d;
            line_addr_q <= line_addr_d;
            rom_addr_q  <= rom_addr_d;
            rom_half_q  <= rom_half_d;
            rom_cs_q    <= rom_cs_d;
            buf_addr_q  <= buf_addr_d;
            buf_data_q  <= buf_data_d;
            buf_wr_q    <= buf_wr_d;
            busy_q      <= busy_d;
        end
    end

    assign line_addr = line_addr_q;
    assign rom_addr  = rom_addr_q;
    assign rom_half  = rom_half_q;
    assign rom_cs    = rom_cs_q;
    assign buf_addr  = buf_addr_q;
    assign buf_data  = buf_data_q;
    assign buf_wr    = buf_wr_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_jtcps1_obj_draw.sv
// Directed bench for jtcps1_obj_draw: object table RAM model, handshaked ROM
// model with per-half data, and a line buffer write recorder.
module tb_jtcps1_obj_draw;

    localparam int unsigned AW = 9;

    logic          clk = 1'b0;
    logic          rst_n, start, flip;
    logic [8:0]    line_addr;
    logic [15:0]   line_data;
    logic [19:0]   rom_addr;
    logic          rom_half, rom_cs, rom_ok;
    logic [31:0]   rom_data;
    logic [AW-1:0] buf_addr;
    logic [8:0]    buf_data;
    logic          buf_wr, busy;

    always #5 clk = ~clk;

    jtcps1_obj_draw #(.AW(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .flip      (flip),
        .line_addr (line_addr),
        .line_data (line_data),
        .rom_addr  (rom_addr),
        .rom_half  (rom_half),
        .rom_cs    (rom_cs),
        .rom_ok    (rom_ok),
        .rom_data  (rom_data),
        .buf_addr  (buf_addr),
        .buf_data  (buf_data),
        .buf_wr    (buf_wr),
        .busy      (busy)
    );

    // Object table: registered read, data one cycle after address
    logic [15:0] tbl [0:511];
    always @(posedge clk) line_data <= tbl[line_addr];

    // ROM: rom_ok after lat cycles of rom_cs; half 0/1 return d_h0/d_h1
    int          lat = 1;
    int          cs_cnt = 0;
    bit          hold_ok = 1'b0;
    bit          late_ok = 1'b0;
    bit          clr = 1'b0;
    logic [31:0] d_h0 = '0, d_h1 = '0;
    int          fcnt = 0;
    logic [19:0] flog_addr [0:7];
    logic        flog_half [0:7];

    always @(negedge clk) begin
        if (clr) fcnt = 0;
        cs_cnt   = rom_cs ? cs_cnt + 1 : 0;
        rom_ok   = late_ok || (rom_cs && (cs_cnt >= lat) && !hold_ok);
        rom_data = rom_half ? d_h1 : d_h0;
        if (rom_ok && rom_cs) begin
            if (fcnt < 8) begin
                flog_addr[fcnt] = rom_addr;
                flog_half[fcnt] = rom_half;
            end
            fcnt++;
        end
    end

    // Line buffer recorder
    int            wcnt = 0;
    logic [8:0]    wmem [0:511];
    bit            wval [0:511];
    logic [AW-1:0] wlog [0:3];

    always @(negedge clk) begin
        if (clr) begin
            wcnt = 0;
            for (int i = 0; i < 512; i++) wval[i] = 1'b0;
        end else if (buf_wr) begin
            wmem[buf_addr] = buf_data;
            wval[buf_addr] = 1'b1;
            if (wcnt < 4) wlog[wcnt] = buf_addr;
            wcnt++;
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        clr = 1'b1;
        @(negedge clk);
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int limit, output int n);
        n = 0;
        while (busy && n < limit) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic set_entry(input int e, input logic [15:0] w0, input logic [15:0] w1,
                             input logic [15:0] w2);
        tbl[e*4]     = w0;
        tbl[e*4 + 1] = w1;
        tbl[e*4 + 2] = w2;
    endtask

    task automatic chk_outputs_zero(input string pfx);
        chk({pfx, "_line_addr"}, 32'(line_addr), 32'h0);
        chk({pfx, "_rom_addr"},  32'(rom_addr),  32'h0);
        chk({pfx, "_rom_half"},  32'(rom_half),  32'h0);
        chk({pfx, "_rom_cs"},    32'(rom_cs),    32'h0);
        chk({pfx, "_buf_addr"},  32'(buf_addr),  32'h0);
        chk({pfx, "_buf_data"},  32'(buf_data),  32'h0);
        chk({pfx, "_buf_wr"},    32'(buf_wr),    32'h0);
        chk({pfx, "_busy"},      32'(busy),      32'h0);
    endtask

    initial begin
        int n;
        int bad;
        bit found;

        rst_n = 1'b0;
        start = 1'b0;
        flip  = 1'b0;
        for (int i = 0; i < 512; i++) tbl[i] = 16'hFFFF;

        // Reset state
        repeat (3) @(negedge clk);
        chk_outputs_zero("rst");
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_buf_wr", 32'(buf_wr), 32'h0);
        chk("post_rst_busy", 32'(busy), 32'h0);

        // Single entry, 2-cycle ROM latency; half 1 fully transparent
        set_entry(0, 16'h0305, 16'h1234, 16'h0040);
        tbl[4] = 16'hFFFF;
        lat  = 2;
        d_h0 = 32'h0000_00FF;
        d_h1 = 32'hFFFF_FFFF;
        clear_logs();
        pulse_start();
        wait_idle(200, n);
        chk("A_busy", 32'(busy), 32'h0);
        chk("A_cycles", 32'(n), 32'd26);
        chk("A_fetches", 32'(fcnt), 32'd2);
        chk("A_rom_addr", 32'(flog_addr[0]), 32'h12343);
        chk("A_half0", 32'(flog_half[0]), 32'h0);
        chk("A_half1", 32'(flog_half[1]), 32'h1);
        chk("A_writes", 32'(wcnt), 32'd8);
        for (int a = 'h40; a < 'h48; a++)
            chk($sformatf("A_pix_%0h", a), 32'({wval[a], wmem[a]}), 32'h251);
        for (int a = 'h48; a < 'h50; a++)
            chk($sformatf("A_nowr_%0h", a), 32'(wval[a]), 32'h0);

        // hflip: half 1 first; only its pixel 0 is opaque (color 1)
        set_entry(0, 16'h0025, 16'h00AB, 16'h0100);
        lat  = 1;
        d_h0 = 32'hFFFF_FFFF;
        d_h1 = 32'hFEFE_FEFF;
        clear_logs();
        pulse_start();
        wait_idle(200, n);
        chk("B_cycles", 32'(n), 32'd24);
        chk("B_fetches", 32'(fcnt), 32'd2);
        chk("B_rom_addr", 32'(flog_addr[0]), 32'h00AB0);
        chk("B_half_first", 32'(flog_half[0]), 32'h1);
        chk("B_half_second", 32'(flog_half[1]), 32'h0);
        chk("B_writes", 32'(wcnt), 32'd1);
        chk("B_first_addr", 32'(wlog[0]), 32'h100);
        chk("B_first_data", 32'(wmem['h100]), 32'h051);

        // Bit order per pixel and later entry overwriting an earlier one
        set_entry(0, 16'h0003, 16'h0001, 16'h0010);
        set_entry(1, 16'h0007, 16'h0002, 16'h0014);
        tbl[8] = 16'hFFFF;
        d_h0 = 32'h1020_4080;
        d_h1 = 32'hFFFF_FFFF;
        clear_logs();
        pulse_start();
        wait_idle(300, n);
        chk("C_cycles", 32'(n), 32'd46);
        chk("C_writes", 32'(wcnt), 32'd16);
        chk("C_px10", 32'(wmem['h10]), 32'h031);
        chk("C_px11", 32'(wmem['h11]), 32'h032);
        chk("C_px13", 32'(wmem['h13]), 32'h038);
        chk("C_px14", 32'(wmem['h14]), 32'h071);
        chk("C_px17", 32'(wmem['h17]), 32'h078);
        chk("C_px1b", 32'(wmem['h1B]), 32'h070);
        chk("C_nowr1c", 32'(wval['h1C]), 32'h0);

        // Screen flip
        set_entry(0, 16'h0001, 16'h0003, 16'h0000);
        tbl[4] = 16'hFFFF;
        d_h0 = 32'h0000_00FF;
        flip = 1'b1;
        clear_logs();
        pulse_start();
        wait_idle(200, n);
        chk("D_flip_writes", 32'(wcnt), 32'd8);
        chk("D_flip_first", 32'(wlog[0]), 32'h1FF);
        chk("D_flip_second", 32'(wlog[1]), 32'h1FE);

        // Position wrap; only x[AW-1:0] is used
        flip = 1'b0;
        set_entry(0, 16'h0001, 16'h0003, 16'hFFFE);
        clear_logs();
        pulse_start();
        wait_idle(200, n);
        chk("D_wrap0", 32'(wlog[0]), 32'h1FE);
        chk("D_wrap1", 32'(wlog[1]), 32'h1FF);
        chk("D_wrap2", 32'(wlog[2]), 32'h000);

        // Full table with no terminator
        for (int e = 0; e < 128; e++) set_entry(e, 16'h0000, 16'(e), 16'h0000);
        d_h0 = 32'hFFFF_FFFF;
        d_h1 = 32'hFFFF_FFFF;
        clear_logs();
        pulse_start();
        wait_idle(4000, n);
        chk("E_busy", 32'(busy), 32'h0);
        chk("E_cycles", 32'(n), 32'd2816);
        chk("E_fetches", 32'(fcnt), 32'd256);
        chk("E_entry1_addr", 32'(flog_addr[2]), 32'h00010);
        chk("E_writes", 32'(wcnt), 32'd0);
        chk("E_last_line_addr", 32'(line_addr), 32'h1FE);

        // Abort during FETCH of entry 3, then a late rom_ok
        for (int e = 0; e < 6; e++) set_entry(e, 16'h0002, 16'(16'h0100 + e), 16'(e * 16));
        tbl[24] = 16'hFFFF;
        d_h0 = 32'h0000_00FF;
        clear_logs();
        pulse_start();
        n = 0;
        while (fcnt < 6 && n < 500) begin
            @(negedge clk);
            n++;
        end
        hold_ok = 1'b1;
        found = 1'b0;
        n = 0;
        while (!found && n < 100) begin
            @(negedge clk);
            n++;
            found = rom_cs && (line_addr[8:2] == 7'd3);
        end
        chk("F_reached_fetch3", 32'(found), 32'h1);
        start = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        late_ok = 1'b1;
        chk("F_rom_cs_drop", 32'(rom_cs), 32'h0);
        chk("F_line_addr0", 32'(line_addr), 32'h0);
        chk("F_buf_wr_c0", 32'(buf_wr), 32'h0);
        chk("F_busy", 32'(busy), 32'h1);
        @(negedge clk);
        late_ok = 1'b0;
        chk("F_buf_wr_c1", 32'(buf_wr), 32'h0);
        chk("F_rom_cs_c1", 32'(rom_cs), 32'h0);
        @(negedge clk);
        hold_ok = 1'b0;
        chk("F_buf_wr_c2", 32'(buf_wr), 32'h0);
        wait_idle(600, n);
        chk("F_done", 32'(busy), 32'h0);
        chk("F_fetches", 32'(fcnt), 32'd18);
        chk("F_entry3_px", 32'(wmem['h30]), 32'h021);

        // Reset during DRAW with start and rom_ok also high
        set_entry(0, 16'h0005, 16'h0001, 16'h0040);
        tbl[4] = 16'hFFFF;
        clear_logs();
        pulse_start();
        n = 0;
        while (!buf_wr && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("G_in_draw", 32'(buf_wr), 32'h1);
        rst_n   = 1'b0;
        start   = 1'b1;
        late_ok = 1'b1;
        @(negedge clk);
        chk_outputs_zero("G_rst");
        start   = 1'b0;
        late_ok = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (buf_wr || busy || rom_cs) bad++;
        end
        chk("G_quiet_after_rst", 32'(bad), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
